instr_fetch_unit: RTL and testbench

//  Fetch stage that produces the instruction fields consumed by Control_Unit.
//  - Owns the PC and requests words from instruction memory over a req/valid handshake.
//  - Latches each returned word and presents it as opcode=instr[6:1], funct7=instr[30]
//    and funct3=instr[14:12], plus register indices.
//  - Holds the instruction until execute signals completion, then advances the PC using
//    the decoder's PCSel feedback.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 12 +
 rtl/instr_field_split.sv | 23 ++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch/decode constants: opcode[6:1] codes, reset NOP word and
// the fetch FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Opcodes are carried without the always-1 bit 0 of the RV32 encoding.
  localparam logic [5:0] OP_R      = 6'b011001;
  localparam logic [5:0] OP_I      = 6'b001001;
  localparam logic [5:0] OP_LOAD   = 6'b000001;
  localparam logic [5:0] OP_STORE  = 6'b010001;
  localparam logic [5:0] OP_BRANCH = 6'b110001;
  localparam logic [5:0] OP_LUI    = 6'b011011;
  localparam logic [5:0] OP_JAL    = 6'b110111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response port: fetch unit is master, memory is slave.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic [31:0]     rdata;
  logic            valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/instr_field_split.sv
// Pure combinational slicer from a 32-bit instruction word to the decode fields.
module instr_field_split (
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        funct7,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign opcode = instr[6:1];
  assign funct7 = instr[30];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Bits not consumed by the control decoder.
  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[29:25], instr[0]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction and holds it until ex_done.
// Minimum two cycles per instruction (FETCH with zero-wait memory, ISSUE with ex_done).
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                ex_done,
  input  logic                PCSel,
  input  logic [XLEN-1:0]     alu_target,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [5:0]          opcode,
  output logic                funct7,
  output logic [2:0]          funct3,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            imem_req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.valid) begin
            instr_q       <= imem.rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // PCSel/alu_target only matter on the completing cycle.
          if (ex_done) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state         <= FETCH;
            pc_q          <= PCSel ? {alu_target[XLEN-1:2], 2'b00} : pc_q + PC_STEP;
          end
        end
        default: begin
          state         <= IDLE;
          instr_valid_q <= 1'b0;
          imem_req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req    = imem_req_q;
  assign imem.addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_STEP;

  logic unused_target_bits;
  assign unused_target_bits = ^alu_target[1:0];

  instr_field_split u_split (
    .instr  (instr_q),
    .opcode (opcode),
    .funct7 (funct7),
    .funct3 (funct3),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios plus randomized traffic against a transaction-level fetch model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_done = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] alu_target = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic        funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc, pc_plus4;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit_if #(.XLEN(32)) imem_if ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem(imem_if.master),
    .ex_done(ex_done), .PCSel(PCSel), .alu_target(alu_target),
    .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "started" = the first post-reset cycle has passed; "have" = an
  // instruction is held awaiting completion.
  logic        m_started = 1'b0;
  logic        m_have = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = NOP_INSTR;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_started = 1'b0; m_have = 1'b0; m_pc = 32'h0; m_instr = NOP_INSTR;
      end else if (!m_started) begin
        m_started = 1'b1;
      end else if (!m_have) begin
        if (imem_if.valid) begin
          m_have = 1'b1;
          m_instr = imem_if.rdata;
        end
      end else if (ex_done) begin
        m_pc = PCSel ? (alu_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
        m_have = 1'b0;
      end
      check("m_req",      {31'b0, imem_if.req}, {31'b0, m_started && !m_have});
      check("m_addr",     imem_if.addr, m_pc);
      check("m_pc",       pc, m_pc);
      check("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("m_valid",    {31'b0, instr_valid}, {31'b0, m_have});
      check("m_instr",    instr, m_instr);
      check("m_opcode",   {26'b0, opcode}, {26'b0, m_instr[6:1]});
      check("m_funct7",   {31'b0, funct7}, {31'b0, m_instr[30]});
      check("m_funct3",   {29'b0, funct3}, {29'b0, m_instr[14:12]});
      check("m_rd",       {27'b0, rd},  {27'b0, m_instr[11:7]});
      check("m_rs1",      {27'b0, rs1}, {27'b0, m_instr[19:15]});
      check("m_rs2",      {27'b0, rs2}, {27'b0, m_instr[24:20]});
    end
  end

  // Apply inputs, then wait to the next falling edge where literal checks happen.
  task automatic step(input logic v, input logic [31:0] d, input logic ex,
                      input logic sel, input logic [31:0] tgt);
    imem_if.valid = v; imem_if.rdata = d;
    ex_done = ex; PCSel = sel; alu_target = tgt;
    @(negedge clk);
  endtask

  initial begin
    imem_if.valid = 1'b0;
    imem_if.rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_req",   {31'b0, imem_if.req}, 32'd0);
    check("rst_pc",    pc, 32'h0);
    check("rst_opcode", {26'b0, opcode}, {26'b0, 6'b001001});
    check("rst_funct3", {29'b0, funct3}, 32'd0);
    rst = 1'b0;

    // Scenario 1: add at address 0
    @(negedge clk);
    check("s1_req",  {31'b0, imem_if.req}, 32'd1);
    check("s1_addr", imem_if.addr, 32'h0);
    step(1'b1, 32'h0000_0033, 1'b0, 1'b0, '0);
    check("s1_valid",  {31'b0, instr_valid}, 32'd1);
    check("s1_opcode", {26'b0, opcode}, {26'b0, 6'b011001});
    check("s1_funct7", {31'b0, funct7}, 32'd0);
    check("s1_funct3", {29'b0, funct3}, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, 32'hFFFF_FF00);
    check("s1_next_addr", imem_if.addr, 32'h4);

    // Scenario 2: sub sets funct7
    step(1'b1, 32'h4000_0033, 1'b0, 1'b0, '0);
    check("s2_funct7", {31'b0, funct7}, 32'd1);
    check("s2_opcode", {26'b0, opcode}, {26'b0, OP_R});
    step(1'b0, '0, 1'b1, 1'b0, '0);
    check("s2_next_addr", imem_if.addr, 32'h8);

    // Scenario 3: bne at pc=8, branch to 0x11 lands on 0x10
    step(1'b1, 32'h0020_9463, 1'b0, 1'b0, '0);
    check("s3_pc",     pc, 32'h8);
    check("s3_funct3", {29'b0, funct3}, 32'd1);
    check("s3_opcode", {26'b0, opcode}, {26'b0, OP_BRANCH});
    step(1'b0, '0, 1'b1, 1'b1, 32'h0000_0011);
    check("s3_next_addr", imem_if.addr, 32'h10);

    // Scenario 4: jump to top of address space, then wrap
    step(1'b1, NOP_INSTR, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFD);
    check("s4_top_addr", imem_if.addr, 32'hFFFF_FFFC);
    step(1'b1, 32'h0000_006F, 1'b0, 1'b0, '0);
    check("s4_pc_plus4", pc_plus4, 32'h0);
    check("s4_opcode", {26'b0, opcode}, {26'b0, OP_JAL});
    step(1'b0, '0, 1'b1, 1'b0, 32'h1234_5678);
    check("s4_wrap_pc", pc, 32'h0);

    // Scenario 5: zero-wait memory, completion every ISSUE cycle
    imem_if.valid = 1'b1; ex_done = 1'b1; PCSel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imem_if.rdata = $urandom;
      @(negedge clk);
      if (i % 2 == 0) begin
        check("s5_issue_valid", {31'b0, instr_valid}, 32'd1);
        check("s5_issue_pc", pc, 32'(i * 2));
      end else begin
        check("s5_fetch_req", {31'b0, imem_if.req}, 32'd1);
        check("s5_fetch_addr", imem_if.addr, 32'((i + 1) * 2));
      end
    end
    imem_if.valid = 1'b0; ex_done = 1'b0;

    // Scenario 6: reset during FETCH with a late response
    begin
      int budget = 10;
      while (!imem_if.req && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("s6_reach_fetch", {31'b0, imem_if.req}, 32'd1);
    end
    rst = 1'b1;
    imem_if.valid = 1'b1; imem_if.rdata = 32'hDEAD_BEEF;
    #1;
    check("s6_instr", instr, NOP_INSTR);
    check("s6_pc", pc, 32'h0);
    check("s6_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("s6_hold_instr", instr, NOP_INSTR);
    check("s6_hold_req", {31'b0, imem_if.req}, 32'd0);
    rst = 1'b0; imem_if.valid = 1'b0;
    @(negedge clk);
    check("s6_refetch_addr", imem_if.addr, 32'h0);
    check("s6_after_instr", instr, NOP_INSTR);

    // Random traffic, including stray strobes and occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 249) == 0);
      imem_if.valid = ($urandom_range(0, 2) == 0);
      imem_if.rdata = $urandom;
      ex_done       = ($urandom_range(0, 2) == 0);
      PCSel         = ($urandom_range(0, 3) == 0);
      alu_target    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                  : $urandom;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
